// File: rtl/axi_sim_ram_pkg.sv
// Shared encodings for the AXI3 simulation RAM: burst types, responses, FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package axi_sim_ram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next beat address for an AXI burst from current addr/len/size/burst.
// Latency: purely combinational.
// Backpressure: none; caller decides when to take the new address.
module axi_burst_addr_gen
  import axi_sim_ram_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [7:0]  len,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  logic [31:0] step;
  logic [31:0] incr_addr;
  logic [31:0] wrap_mask;

  // FIXED holds, WRAP folds the increment into a (len+1)*size window, others increment
  always_comb begin
    step      = 32'd1 << size;
    incr_addr = addr + step;
    wrap_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_sim_ram.sv
// AXI3 slave memory with FIXED/INCR/WRAP bursts, byte strobes and independent read/write FSMs.
// Latency: first rvalid RD_LAT cycles after the AR handshake; one beat per cycle after that.
// Backpressure: rdata/rvalid held while rready=0; bvalid held until bready; one burst per channel.
module axi_sim_ram
  import axi_sim_ram_pkg::*;
#(
  parameter int    DATA_W     = 32,
  parameter int    ID_W       = 4,
  parameter int    DEPTH_LOG2 = 16,
  parameter int    RD_LAT     = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     arid,
  input  logic [31:0]         araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ID_W-1:0]     awid,
  input  logic [31:0]         awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     wid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);

  localparam int SW = DATA_W / 8;
  localparam int B  = $clog2(SW);

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // ---------------- read path ----------------
  rd_state_t r_state, r_nstate;
  logic [31:0] r_addr, r_next_addr, fetch_addr;
  logic [7:0]  r_len, r_cnt;
  logic [2:0]  r_size, lat_cnt;
  logic [1:0]  r_burst;
  logic        ar_hs, r_hs, fetch_en;
  logic [DEPTH_LOG2-1:0] fetch_idx;

  axi_burst_addr_gen u_rd_agen (
    .addr(r_addr), .len(r_len), .size(r_size), .burst(r_burst), .next_addr(r_next_addr)
  );

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  // read state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_nstate;
  end

  // read next-state: RD_LAT=1 skips the wait state so data follows the handshake directly
  always_comb begin
    r_nstate = r_state;
    case (r_state)
      R_IDLE: if (ar_hs) r_nstate = (RD_LAT == 1) ? R_DATA : R_WAIT;
      R_WAIT: if (lat_cnt <= 3'd1) r_nstate = R_DATA;
      R_DATA: if (r_hs && r_cnt == 8'd0) r_nstate = R_IDLE;
      default: r_nstate = R_IDLE;
    endcase
  end

  // read outputs; reset forces every valid/ready low while it is held
  always_comb begin
    arready = (r_state == R_IDLE) && !rst;
    rvalid  = (r_state == R_DATA) && !rst;
    rlast   = rvalid && (r_cnt == 8'd0);
    rresp   = RESP_OKAY;
  end

  // read burst bookkeeping: latch on AR, step on each accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      rid     <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      lat_cnt <= '0;
    end else if (ar_hs) begin
      rid     <= arid;
      r_addr  <= araddr;
      r_len   <= arlen;
      r_size  <= arsize;
      r_burst <= arburst;
      r_cnt   <= arlen;
      lat_cnt <= 3'(RD_LAT - 1);
    end else begin
      if (r_state == R_WAIT) lat_cnt <= lat_cnt - 3'd1;
      if (r_hs) begin
        r_addr <= r_next_addr;
        r_cnt  <= r_cnt - 8'd1;
      end
    end
  end

  // fetch the word for the beat about to be presented; addr source depends on where we come from
  always_comb begin
    case (r_state)
      R_IDLE:  fetch_addr = araddr;
      R_DATA:  fetch_addr = r_next_addr;
      default: fetch_addr = r_addr;
    endcase
    fetch_en  = ((r_state != R_DATA) && (r_nstate == R_DATA)) || (r_hs && r_cnt != 8'd0);
    fetch_idx = fetch_addr[DEPTH_LOG2+B-1:B];
  end

  // registered read data; same-edge writes are not visible, giving pre-write data on collision
  always_ff @(posedge clk) begin
    if (rst)           rdata <= '0;
    else if (fetch_en) rdata <= mem[fetch_idx];
  end

  // ---------------- write path ----------------
  wr_state_t w_state, w_nstate;
  logic [31:0] w_addr, w_next_addr;
  logic [7:0]  w_len, w_cnt;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_err, aw_hs, w_hs;
  logic [DEPTH_LOG2-1:0] w_idx;

  axi_burst_addr_gen u_wr_agen (
    .addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst), .next_addr(w_next_addr)
  );

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign w_idx = w_addr[DEPTH_LOG2+B-1:B];

  // write state register
  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_nstate;
  end

  // write next-state: burst length comes from awlen, wlast only feeds the error flag
  always_comb begin
    w_nstate = w_state;
    case (w_state)
      W_IDLE: if (aw_hs) w_nstate = W_DATA;
      W_DATA: if (w_hs && w_cnt == 8'd0) w_nstate = W_RESP;
      W_RESP: if (bvalid && bready) w_nstate = W_IDLE;
      default: w_nstate = W_IDLE;
    endcase
  end

  // write outputs
  always_comb begin
    awready = (w_state == W_IDLE) && !rst;
    wready  = (w_state == W_DATA) && !rst;
    bvalid  = (w_state == W_RESP) && !rst;
    bresp   = (bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;
  end

  // write burst bookkeeping and wlast/length mismatch tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      bid     <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      bid     <= awid;
      w_addr  <= awaddr;
      w_len   <= awlen;
      w_size  <= awsize;
      w_burst <= awburst;
      w_cnt   <= awlen;
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_addr <= w_next_addr;
      w_cnt  <= w_cnt - 8'd1;
      if (wlast != (w_cnt == 8'd0)) w_err <= 1'b1;
    end
  end

  // byte-lane writes; memory has no reset so contents survive rst
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int i = 0; i < SW; i++) begin
        if (wstrb[i]) mem[w_idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // wid and the aliased upper/lower address bits are intentionally ignored
  logic unused_ok;
  assign unused_ok = ^{wid, fetch_addr, w_addr};

endmodule
